// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer width and Gray encoding,
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  // Pointers carry one extra bit so a wrapped pointer can be told apart from an empty FIFO.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer, empty, almost-empty and level controller for the async FIFO.
// Define RD_UNDERFLOW_EN to add the sticky underflow flag output rerr.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  ralmost_empty,
`ifdef RD_UNDERFLOW_EN
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  rerr
`else
  output logic [ADDR_WIDTH:0]   rlevel
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          rae_q, rae_d;
  logic          racc;
  logic [PW-1:0] wbin;

  gray2bin #(.WIDTH(PW)) u_wptr_dec (
    .gray_i (rq2_wptr),
    .bin_o  (wbin)
  );

  // Flags are computed against rbin_d so a read and an arriving write in the
  // same cycle are both reflected at the next edge.
  always_comb begin
    racc     = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{(PW-1){1'b0}}, racc};
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = wbin - rbin_d;
    rae_d    = (rlevel_d <= AE_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      rlevel_q <= rlevel_d;
    end
  end

`ifdef RD_UNDERFLOW_EN
  logic rerr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rerr_q <= 1'b0;
    end else begin
      rerr_q <= rerr_q | (rinc & rempty_q);
    end
  end

  assign rerr = rerr_q;
`endif

  assign raddr         = rbin_q[ADDR_WIDTH-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;

endmodule
